conv_mac_sequencer: RTL and testbench

//  Sequences one KSIZE x KSIZE convolution window through the registered MAC (mac_manual) to produce one output pixel.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_mac_sequencer_if.sv | 35 +++
 rtl/conv_tap_counter.sv | 45 ++++
 rtl/mac_manual.sv | 28 ++
 rtl/conv_mac_sequencer.sv | 110 +++++++++++
 tb/tb_conv_mac_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution MAC sequencer.
// Default geometry, the FSM state type and the unsigned saturation helper.
package conv_pkg;

    localparam int DEF_N     = 18;
    localparam int DEF_KSIZE = 3;
    localparam int DEF_IMG_W = 32;
    localparam int DEF_AW    = 10;
    localparam int K         = DEF_KSIZE * DEF_KSIZE;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN1,
        DRAIN2,
        DONE
    } state_t;

    // Clamp an unsigned value to the largest n-bit number.
    function automatic logic [63:0] sat_n(input logic [63:0] x, input int n);
        logic [63:0] max_v;
        max_v = (64'd1 << n) - 64'd1;
        return (x > max_v) ? max_v : x;
    endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Bundles the request, RAM, MAC and result signals of the convolution sequencer.
// The slave side is the sequencer; the master side is whatever surrounds it.
interface conv_mac_sequencer_if #(
    parameter int N  = conv_pkg::DEF_N,
    parameter int AW = conv_pkg::DEF_AW
);
    logic          start;
    logic          ready;
    logic          abort;
    logic [AW-1:0] pix_base;
    logic [AW-1:0] wgt_base;
    logic [N-1:0]  bias;
    logic [AW-1:0] pix_addr;
    logic [AW-1:0] wgt_addr;
    logic [N-1:0]  pix_data;
    logic [N-1:0]  wgt_data;
    logic          mac_sclr;
    logic [N-1:0]  mac_a;
    logic [N-1:0]  mac_b;
    logic [N-1:0]  mac_c;
    logic [N+9:0]  mac_p;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    modport slave (
        input  start, abort, pix_base, wgt_base, bias, pix_data, wgt_data, mac_p, out_ready,
        output ready, pix_addr, wgt_addr, mac_sclr, mac_a, mac_b, mac_c, out_valid, out_data
    );

    modport master (
        output start, abort, pix_base, wgt_base, bias, pix_data, wgt_data, mac_p, out_ready,
        input  ready, pix_addr, wgt_addr, mac_sclr, mac_a, mac_b, mac_c, out_valid, out_data
    );
endinterface

// File: rtl/conv_tap_counter.sv
// Walks row/col/tap across one KSIZE x KSIZE window, one tap per enabled cycle.
// o_last flags the final tap so the sequencer can leave the issue phase.
module conv_tap_counter #(
    parameter int KSIZE = 3,
    parameter int RW    = (KSIZE > 1) ? $clog2(KSIZE) : 1,
    parameter int TW    = $clog2(KSIZE * KSIZE)
) (
    input  logic          clk,
    input  logic          sclr_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [RW-1:0] o_row,
    output logic [RW-1:0] o_col,
    output logic [TW-1:0] o_tap,
    output logic          o_last
);
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_col;
    logic [TW-1:0] r_tap;

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            r_row <= '0;
            r_col <= '0;
            r_tap <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
            r_tap <= '0;
        end else if (i_en) begin
            r_tap <= r_tap + 1'b1;
            if (r_col == RW'(KSIZE - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_tap  = r_tap;
    assign o_last = (r_tap == TW'(KSIZE * KSIZE - 1));
endmodule

// File: rtl/mac_manual.sv
// Registered multiply-accumulate: p = reg(a*b) + reg(c), synchronous clear.
// The product is kept to the result width; callers keep operands in range.
module mac_manual #(
    parameter int N  = 18,
    parameter int PW = N + 10
) (
    input  logic          clk,
    input  logic          i_sclr,
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
    input  logic [N-1:0]  i_c,
    output logic [PW-1:0] o_p
);
    logic [PW-1:0] r_prod;
    logic [N-1:0]  r_c;

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_prod <= '0;
            r_c    <= '0;
        end else begin
            r_prod <= PW'(i_a) * PW'(i_b);
            r_c    <= i_c;
        end
    end

    assign o_p = r_prod + PW'(r_c);
endmodule

// File: rtl/conv_mac_sequencer.sv
// Drives one convolution window through an external registered MAC and
// returns the saturated sum on a valid/ready port.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int KSIZE = DEF_KSIZE,
    parameter int IMG_W = DEF_IMG_W,
    parameter int AW    = DEF_AW
) (
    input logic                  clk,
    input logic                  sclr_n,
    conv_mac_sequencer_if.slave  bus
);
    localparam int RW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int TW = $clog2(KSIZE * KSIZE);

    state_t        r_state;
    logic [AW-1:0] r_pix_base;
    logic [AW-1:0] r_wgt_base;
    logic [N-1:0]  r_bias;
    logic [N-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_mac_sclr;
    logic          r_feed_v;
    logic          r_first;

    logic [RW-1:0] w_row;
    logic [RW-1:0] w_col;
    logic [TW-1:0] w_tap;
    logic          w_last;
    logic          w_run;
    logic          w_accept;
    logic          w_abort;
    logic          w_issue;
    logic [N-1:0]  w_sat_p;

    assign w_run    = (r_state == RUN);
    assign w_accept = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_abort  = (r_state != IDLE) && bus.abort;
    assign w_issue  = w_run && !bus.abort;
    assign w_sat_p  = N'(sat_n(64'(bus.mac_p), N));

    conv_tap_counter #(.KSIZE(KSIZE)) u_cnt (
        .clk    (clk),
        .sclr_n (sclr_n),
        .i_clr  (w_accept),
        .i_en   (w_issue),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_tap  (w_tap),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pix_base <= bus.pix_base;
            r_wgt_base <= bus.wgt_base;
            r_bias     <= bus.bias;
        end
    end

    // Feed flags trail the issue by one cycle to line up with RAM read data.
    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            r_state     <= IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_mac_sclr  <= 1'b1;
            r_feed_v    <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            r_mac_sclr <= w_abort;
            r_feed_v   <= w_issue;
            r_first    <= w_issue && (w_tap == '0);
            if (w_abort) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE:    if (w_accept) r_state <= RUN;
                    RUN:     if (w_last) r_state <= DRAIN1;
                    DRAIN1:  r_state <= DRAIN2;
                    DRAIN2: begin
                        r_out_data  <= w_sat_p;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                    DONE: begin
                        if (bus.out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pix_addr  = w_run ? (r_pix_base + AW'(w_row) * AW'(IMG_W) + AW'(w_col)) : '0;
    assign bus.wgt_addr  = w_run ? (r_wgt_base + AW'(w_tap)) : '0;
    assign bus.mac_a     = r_feed_v ? bus.pix_data : '0;
    assign bus.mac_b     = r_feed_v ? bus.wgt_data : '0;
    assign bus.mac_c     = r_feed_v ? (r_first ? r_bias : w_sat_p) : '0;
    assign bus.mac_sclr  = r_mac_sclr;
    assign bus.ready     = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer with mac_manual and two 1-cycle RAM models.
// Expected window results are queued at accept time and checked on output.
module tb_conv_mac_sequencer;
    localparam int N     = 18;
    localparam int AW    = 10;
    localparam int KS    = 3;
    localparam int IMG_W = 32;
    localparam logic [63:0] MAXV = (64'd1 << N) - 64'd1;

    logic clk = 1'b0;
    logic sclr_n = 1'b0;
    always #5 clk = ~clk;

    conv_mac_sequencer_if #(.N(N), .AW(AW)) bus();

    conv_mac_sequencer #(.N(N), .KSIZE(KS), .IMG_W(IMG_W), .AW(AW)) dut (
        .clk    (clk),
        .sclr_n (sclr_n),
        .bus    (bus)
    );

    mac_manual #(.N(N)) u_mac (
        .clk    (clk),
        .i_sclr (bus.mac_sclr),
        .i_a    (bus.mac_a),
        .i_b    (bus.mac_b),
        .i_c    (bus.mac_c),
        .o_p    (bus.mac_p)
    );

    logic [N-1:0] pix_mem [1024];
    logic [N-1:0] wgt_mem [1024];

    always @(posedge clk) begin
        bus.pix_data <= pix_mem[bus.pix_addr];
        bus.wgt_data <= wgt_mem[bus.wgt_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] model(input logic [AW-1:0] pb, input logic [AW-1:0] wb,
                                           input logic [N-1:0] b);
        logic [63:0]   acc;
        logic [AW-1:0] pa;
        logic [AW-1:0] wa;
        acc = 64'(b);
        for (int r = 0; r < KS; r++) begin
            for (int c = 0; c < KS; c++) begin
                pa  = pb + AW'(r * IMG_W + c);
                wa  = wb + AW'(r * KS + c);
                acc = acc + 64'(pix_mem[pa]) * 64'(wgt_mem[wa]);
                if (acc > MAXV) acc = MAXV;
            end
        end
        return acc[N-1:0];
    endfunction

    task automatic fill_const(input logic [N-1:0] pv, input logic [N-1:0] wv);
        for (int i = 0; i < 1024; i++) begin
            pix_mem[i] = pv;
            wgt_mem[i] = wv;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 1024; i++) begin
            pix_mem[i] = N'($urandom_range(0, 8191));
            wgt_mem[i] = N'($urandom_range(0, 8191));
        end
    endtask

    task automatic start_window(input logic [AW-1:0] pb, input logic [AW-1:0] wb,
                                input logic [N-1:0] b);
        bus.pix_base = pb;
        bus.wgt_base = wb;
        bus.bias     = b;
        bus.start    = 1'b1;
        exp_q.push_back(model(pb, wb, b));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_out(input int budget, output bit ok);
        int cyc;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            if (bus.out_valid === 1'b1) ok = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.abort = 0; bus.out_ready = 1;
        bus.pix_base = 0; bus.wgt_base = 0; bus.bias = 0;
        fill_const(18'd2, 18'd3);
        sclr_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.ready, bus.out_valid, bus.mac_sclr} !== 3'b101)
            $display("FAIL reset_ctrl: rdy/vld/sclr=%b expected 101", {bus.ready, bus.out_valid, bus.mac_sclr});
        else n_pass++;
        n_checks++;
        if ({bus.pix_addr, bus.wgt_addr, bus.out_data} !== '0)
            $display("FAIL reset_data: pa=%0d wa=%0d od=%0d expected 0", bus.pix_addr, bus.wgt_addr, bus.out_data);
        else n_pass++;
        sclr_n = 1'b1;
        n_checks++;
        if (bus.mac_sclr !== 1'b1) $display("FAIL reset_sclr_hold: mac_sclr=%b expected 1", bus.mac_sclr);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.mac_sclr !== 1'b0) $display("FAIL reset_sclr_drop: mac_sclr=%b expected 0", bus.mac_sclr);
        else n_pass++;

        start_window(10'd0, 10'd0, 18'd5);
        tick(); tick(); tick();
        n_checks++;
        if (bus.ready !== 1'b0) $display("FAIL midrun_busy: ready=%b expected 0", bus.ready);
        else n_pass++;
        sclr_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.ready, bus.out_valid, bus.mac_sclr, bus.pix_addr} !== {3'b101, 10'd0})
            $display("FAIL midrun_reset: rdy/vld/sclr=%b pa=%0d expected 101 and 0",
                     {bus.ready, bus.out_valid, bus.mac_sclr}, bus.pix_addr);
        else n_pass++;
        exp_q.delete();
        tick();
        sclr_n = 1'b1;
        n_checks++;
        if (bus.mac_sclr !== 1'b1) $display("FAIL midrun_sclr_1st: mac_sclr=%b expected 1", bus.mac_sclr);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.mac_sclr !== 1'b0) $display("FAIL midrun_sclr_2nd: mac_sclr=%b expected 0", bus.mac_sclr);
        else n_pass++;
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (bus.out_valid === 1'b1) seen++;
                tick();
            end
            n_checks++;
            if (seen != 0) $display("FAIL midrun_no_output: valid cycles=%0d expected 0", seen);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        int first;
        logic [N-1:0] got;
        logic [N-1:0] exp_v;
        fill_const(18'd2, 18'd3);
        bus.out_ready = 1'b1;
        first = -1;
        got   = '0;
        start_window(10'd0, 10'd0, 18'd5);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (bus.out_valid === 1'b1 && first < 0) begin
                first = cyc;
                got   = bus.out_data;
            end
            tick();
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (first != 12) $display("FAIL single_latency: first valid cycle=%0d expected 12", first);
        else n_pass++;
        n_checks++;
        if (got !== 18'd59) $display("FAIL single_value: out_data=%0d expected 59", got);
        else n_pass++;
        n_checks++;
        if (got !== exp_v) $display("FAIL single_model: out_data=%0d expected %0d", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_addressing();
        int exp_pix [9];
        bit ok;
        logic [N-1:0] exp_v;
        exp_pix = '{100, 101, 102, 132, 133, 134, 164, 165, 166};
        fill_rand();
        start_window(10'd100, 10'd200, 18'd7);
        for (int t = 0; t < 9; t++) begin
            n_checks++;
            if (bus.pix_addr !== AW'(exp_pix[t]))
                $display("FAIL pix_addr_t%0d: got %0d expected %0d", t, bus.pix_addr, exp_pix[t]);
            else n_pass++;
            n_checks++;
            if (bus.wgt_addr !== AW'(200 + t))
                $display("FAIL wgt_addr_t%0d: got %0d expected %0d", t, bus.wgt_addr, 200 + t);
            else n_pass++;
            tick();
        end
        wait_out(40, ok);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL addr_result: out_valid never rose, expected %0d", exp_v);
        else if (bus.out_data !== exp_v)
            $display("FAIL addr_result: out_data=%0d expected %0d", bus.out_data, exp_v);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        bit ok;
        logic [N-1:0] exp_v;
        fill_const(18'd511, 18'd511);
        start_window(10'd0, 10'd0, 18'd262143);
        wait_out(40, ok);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!ok || bus.out_data !== 18'd262143)
            $display("FAIL sat_value: valid=%b out_data=%0d expected 262143", ok, bus.out_data);
        else n_pass++;
        n_checks++;
        if (bus.out_data !== exp_v) $display("FAIL sat_model: out_data=%0d expected %0d", bus.out_data, exp_v);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [N-1:0] got;
        logic [N-1:0] exp_v;
        fill_rand();
        bus.out_ready = 1'b0;
        start_window(10'd5, 10'd9, 18'd1234);
        wait_out(40, ok);
        got   = bus.out_data;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp_v) $display("FAIL bp_result: valid=%b out_data=%0d expected %0d", ok, got, exp_v);
        else n_pass++;
        bus.pix_base = 10'd700;
        bus.wgt_base = 10'd50;
        bus.bias     = 18'd77;
        bus.start    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bus.out_valid, bus.ready} !== 2'b10 || bus.out_data !== got)
                $display("FAIL bp_hold_%0d: vld/rdy=%b data=%0d expected 10 and %0d",
                         i, {bus.out_valid, bus.ready}, bus.out_data, got);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.ready} !== 2'b01)
            $display("FAIL bp_release: vld/rdy=%b expected 01", {bus.out_valid, bus.ready});
        else n_pass++;
        exp_q.push_back(model(10'd700, 10'd50, 18'd77));
        tick();
        bus.start = 1'b0;
        n_checks++;
        if (bus.ready !== 1'b0) $display("FAIL bp_accept: ready=%b expected 0", bus.ready);
        else n_pass++;
        wait_out(40, ok);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!ok || bus.out_data !== exp_v)
            $display("FAIL bp_next_result: valid=%b out_data=%0d expected %0d", ok, bus.out_data, exp_v);
        else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        bit ok;
        int seen;
        logic [N-1:0] exp_v;
        fill_rand();
        start_window(10'd300, 10'd40, 18'd99);
        tick(); tick(); tick(); tick();
        n_checks++;
        if (bus.wgt_addr !== 10'd44) $display("FAIL abort_at_tap4: wgt_addr=%0d expected 44", bus.wgt_addr);
        else n_pass++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        void'(exp_q.pop_front());
        n_checks++;
        if ({bus.ready, bus.mac_sclr, bus.out_valid} !== 3'b110)
            $display("FAIL abort_idle: rdy/sclr/vld=%b expected 110", {bus.ready, bus.mac_sclr, bus.out_valid});
        else n_pass++;
        tick();
        n_checks++;
        if (bus.mac_sclr !== 1'b0) $display("FAIL abort_pulse: mac_sclr=%b expected 0", bus.mac_sclr);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) $display("FAIL abort_no_output: valid cycles=%0d expected 0", seen);
        else n_pass++;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.pix_addr !== 10'd0)
            $display("FAIL abort_start_prio: ready=%b pa=%0d expected 1 and 0", bus.ready, bus.pix_addr);
        else n_pass++;
        start_window(10'd300, 10'd40, 18'd99);
        wait_out(40, ok);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!ok || bus.out_data !== exp_v)
            $display("FAIL abort_recover: valid=%b out_data=%0d expected %0d", ok, bus.out_data, exp_v);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [AW-1:0] pb;
        logic [AW-1:0] wb;
        logic [N-1:0]  exp_v;
        fill_rand();
        for (int w = 0; w < 4; w++) begin
            pb = (w == 0) ? 10'd1000 : AW'($urandom_range(0, 1023));
            wb = (w == 0) ? 10'd1020 : AW'($urandom_range(0, 1023));
            start_window(pb, wb, N'($urandom_range(0, 262143)));
            wait_out(40, ok);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (!ok || bus.out_data !== exp_v)
                $display("FAIL b2b_%0d: valid=%b out_data=%0d expected %0d", w, ok, bus.out_data, exp_v);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_queue: %0d results left, expected 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_addressing();
        test_saturation();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
